// File: rtl/fire_detect_mc_if.sv
// Sample/alarm bundle between the sensor mux and fire_detect_mc.
// The master drives samples and alarm clears; the slave (detector) returns status.
interface fire_detect_mc_if #(
    parameter int unsigned W   = 16,
    parameter int unsigned NCH = 4,
    parameter int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1
);
    logic           data_valid;
    logic [CW-1:0]  ch_id;
    logic [W-1:0]   lux_in;
    logic [NCH-1:0] alarm_clr;
    logic [NCH-1:0] fire_detected;
    logic           fire_any;
    logic [NCH-1:0] alarm_latched;
    logic           out_valid;

    modport master (
        output data_valid, ch_id, lux_in, alarm_clr,
        input  fire_detected, fire_any, alarm_latched, out_valid
    );

    modport slave (
        input  data_valid, ch_id, lux_in, alarm_clr,
        output fire_detected, fire_any, alarm_latched, out_valid
    );
endinterface

// File: rtl/fire_detect_mc.sv
// Multi-channel EMA fire detector for time-multiplexed lux sensors.
// Each channel keeps an EMA baseline and a hysteretic IDLE/FIRE state that
// changes only after PERSIST consecutive qualifying samples; alarms are sticky.
module fire_detect_mc #(
    parameter int unsigned W       = 16,
    parameter int unsigned NCH     = 4,
    parameter int unsigned SHIFT   = 6,
    parameter int unsigned ALPHA   = 20,
    parameter int unsigned TH_ON   = 200,
    parameter int unsigned TH_OFF  = 100,
    parameter int unsigned PERSIST = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    fire_detect_mc_if.slave  bus
);
    localparam int unsigned CW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned CNTW = $clog2(PERSIST + 1);
    localparam int unsigned EW   = W + SHIFT + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FIRE = 1'b1
    } state_t;

    state_t          state_q [NCH];
    state_t          state_d [NCH];
    logic [W-1:0]    ema_q   [NCH];
    logic [W-1:0]    ema_d   [NCH];
    logic [CNTW-1:0] cnt_q   [NCH];
    logic [CNTW-1:0] cnt_d   [NCH];
    logic [NCH-1:0]  init_q, init_d;
    logic [NCH-1:0]  alarm_q, alarm_d;
    logic [NCH-1:0]  fire_d;
    logic            fire_any_q, fire_any_d;
    logic            out_valid_q, out_valid_d;
    logic            accept;

    // Per-channel next state: only the addressed channel moves on an accepted sample
    always_comb begin
        logic [EW-1:0]   mix;
        logic [W-1:0]    ema_new;
        logic [W:0]      lux_ext;
        logic [W:0]      thr_on;
        logic [W:0]      thr_off;
        logic [CNTW-1:0] cnt_inc;

        accept      = bus.data_valid && ({1'b0, bus.ch_id} < (CW+1)'(NCH));
        out_valid_d = accept;
        lux_ext     = {1'b0, bus.lux_in};
        fire_d      = '0;
        init_d      = init_q;
        alarm_d     = alarm_q;

        for (int unsigned i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            ema_d[i]   = ema_q[i];
            cnt_d[i]   = cnt_q[i];

            mix     = EW'(ALPHA) * EW'(bus.lux_in)
                    + EW'((32'd1 << SHIFT) - ALPHA) * EW'(ema_q[i]);
            ema_new = mix[SHIFT +: W];
            thr_on  = {1'b0, ema_q[i]} + (W+1)'(TH_ON);
            thr_off = {1'b0, ema_q[i]} + (W+1)'(TH_OFF);
            cnt_inc = cnt_q[i] + 1'b1;

            if (accept && (bus.ch_id == CW'(i))) begin
                if (!init_q[i]) begin
                    ema_d[i]  = bus.lux_in;
                    init_d[i] = 1'b1;
                    cnt_d[i]  = '0;
                end else begin
                    unique case (state_q[i])
                        ST_IDLE: begin
                            // Baseline tracks only samples that do not exceed it
                            if (lux_ext > thr_on) begin
                                if (cnt_inc == CNTW'(PERSIST)) begin
                                    state_d[i] = ST_FIRE;
                                    cnt_d[i]   = '0;
                                end else begin
                                    cnt_d[i] = cnt_inc;
                                end
                            end else begin
                                cnt_d[i] = '0;
                                ema_d[i] = ema_new;
                            end
                        end
                        ST_FIRE: begin
                            if (lux_ext <= thr_off) begin
                                if (cnt_inc == CNTW'(PERSIST)) begin
                                    state_d[i] = ST_IDLE;
                                    cnt_d[i]   = '0;
                                end else begin
                                    cnt_d[i] = cnt_inc;
                                end
                            end else begin
                                cnt_d[i] = '0;
                            end
                        end
                        default: state_d[i] = ST_IDLE;
                    endcase
                end
            end

            fire_d[i]  = (state_d[i] == ST_FIRE);
            // Entering FIRE sets the alarm and overrides a simultaneous clear
            alarm_d[i] = ((state_d[i] == ST_FIRE) && (state_q[i] == ST_IDLE))
                       || (alarm_q[i] && !bus.alarm_clr[i]);
        end

        fire_any_d = |fire_d;
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                state_q[i] <= ST_IDLE;
                ema_q[i]   <= '0;
                cnt_q[i]   <= '0;
            end
            init_q      <= '0;
            alarm_q     <= '0;
            fire_any_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                ema_q[i]   <= ema_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            init_q      <= init_d;
            alarm_q     <= alarm_d;
            fire_any_q  <= fire_any_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Drive the status outputs from registered state
    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            bus.fire_detected[i] = (state_q[i] == ST_FIRE);
        end
        bus.fire_any      = fire_any_q;
        bus.alarm_latched = alarm_q;
        bus.out_valid     = out_valid_q;
    end
endmodule

// File: tb/tb_fire_detect_mc.sv
// Scoreboard bench for fire_detect_mc: each accepted sample pushes its expected
// status; a monitor pops and compares whenever out_valid is seen.
module tb_fire_detect_mc;
    localparam int W   = 16;
    localparam int NCH = 3;
    localparam int CW  = 2;

    typedef struct {
        logic [NCH-1:0] fd;
        logic [NCH-1:0] al;
        string          name;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    fire_detect_mc_if #(.W(W), .NCH(NCH), .CW(CW)) bus ();

    fire_detect_mc #(
        .W(W), .NCH(NCH), .SHIFT(6), .ALPHA(20),
        .TH_ON(200), .TH_OFF(100), .PERSIST(3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check_out(input string name, input logic [2*NCH:0] act,
                             input logic [2*NCH:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got fd/any/al=%b required %b", name, act, req);
        end
    endtask

    task automatic check_valid_low(input string name);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s: out_valid got %b required 0", name, bus.out_valid);
        end
    endtask

    // Monitor: compare status against the oldest expectation on each out_valid
    always @(negedge clk) begin
        if (rst_n && bus.out_valid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got 1 required 0 (queue empty)");
            end else begin
                mon_e = q.pop_front();
                check_out(mon_e.name,
                          {bus.fire_detected, bus.fire_any, bus.alarm_latched},
                          {mon_e.fd, |mon_e.fd, mon_e.al});
            end
        end
    end

    task automatic send(input string name, input int ch, input int lux,
                        input logic [NCH-1:0] clr, input logic [NCH-1:0] efd,
                        input logic [NCH-1:0] eal);
        exp_t e;
        @(negedge clk);
        bus.data_valid = 1'b1;
        bus.ch_id      = CW'(ch);
        bus.lux_in     = W'(lux);
        bus.alarm_clr  = clr;
        if (ch < NCH) begin
            e.fd   = efd;
            e.al   = eal;
            e.name = name;
            q.push_back(e);
        end else begin
            @(negedge clk);
            bus.data_valid = 1'b0;
            bus.alarm_clr  = '0;
            check_valid_low(name);
            check_out(name, {bus.fire_detected, bus.fire_any, bus.alarm_latched},
                      {efd, |efd, eal});
        end
    endtask

    task automatic drain(input string name);
        @(negedge clk);
        bus.data_valid = 1'b0;
        bus.alarm_clr  = '0;
        for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s: pending expectations got %0d required 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic do_reset(input string name);
        drain({name, "_drain"});
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_out(name, {bus.fire_detected, bus.fire_any, bus.alarm_latched}, '0);
        check_valid_low(name);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.data_valid = 1'b0;
        bus.ch_id      = '0;
        bus.lux_in     = '0;
        bus.alarm_clr  = '0;
        repeat (3) @(negedge clk);
        check_out("reset_state", {bus.fire_detected, bus.fire_any, bus.alarm_latched}, '0);
        check_valid_low("reset_valid");
        rst_n = 1'b1;

        // Count restarts on a non-exceeding sample; ch1 samples equal to thr_on never count
        send("a_init0", 0, 1000, 3'b000, 3'b000, 3'b000);
        send("a_x1",    0, 1300, 3'b000, 3'b000, 3'b000);
        send("a_x2",    0, 1300, 3'b000, 3'b000, 3'b000);
        send("a_dip",   0,  900, 3'b000, 3'b000, 3'b000);
        send("a_y1",    0, 1300, 3'b000, 3'b000, 3'b000);
        send("a_y2",    0, 1300, 3'b000, 3'b000, 3'b000);
        send("a_init1", 1, 1000, 3'b000, 3'b000, 3'b000);
        send("a_eq1",   1, 1200, 3'b000, 3'b000, 3'b000);
        send("a_eq2",   1, 1200, 3'b000, 3'b000, 3'b000);
        send("a_eq3",   1, 1200, 3'b000, 3'b000, 3'b000);
        send("a_y3",    0, 1300, 3'b000, 3'b001, 3'b001);
        do_reset("reset_a");

        // Fire on the third exceeding sample against a frozen baseline
        send("b_init0", 0, 1000, 3'b000, 3'b000, 3'b000);
        send("b_x1",    0, 1300, 3'b000, 3'b000, 3'b000);
        send("b_x2",    0, 1300, 3'b000, 3'b000, 3'b000);
        send("b_fire",  0, 1300, 3'b000, 3'b001, 3'b001);

        // Hysteresis: above thr_off keeps FIRE, third 1050 clears; alarm stays
        send("c_hold1", 0, 1150, 3'b000, 3'b001, 3'b001);
        send("c_hold2", 0, 1150, 3'b000, 3'b001, 3'b001);
        send("c_clr1",  0, 1050, 3'b000, 3'b001, 3'b001);
        send("c_clr2",  0, 1050, 3'b000, 3'b001, 3'b001);
        send("c_exit",  0, 1050, 3'b000, 3'b000, 3'b001);

        // alarm_clr releases ch0; ch1 fires while ch2 near full scale does not
        send("d_init1", 1,   500, 3'b001, 3'b000, 3'b000);
        send("d_init2", 2, 60000, 3'b000, 3'b000, 3'b000);
        send("d1a",     1,   800, 3'b000, 3'b000, 3'b000);
        send("d2a",     2, 60100, 3'b000, 3'b000, 3'b000);
        send("d1b",     1,   800, 3'b000, 3'b000, 3'b000);
        send("d2b",     2, 60100, 3'b000, 3'b000, 3'b000);
        send("d1c",     1,   800, 3'b000, 3'b010, 3'b010);
        send("d2c",     2, 60100, 3'b000, 3'b010, 3'b010);

        // Set beats simultaneous clear; out-of-range channel is ignored; clear leaves fd alone
        send("e_x1",    0, 1300, 3'b000, 3'b010, 3'b010);
        send("e_x2",    0, 1300, 3'b000, 3'b010, 3'b010);
        send("e_fire",  0, 1300, 3'b001, 3'b011, 3'b011);
        send("e_ign",   3, 60000, 3'b000, 3'b011, 3'b011);
        send("e_clr1",  0, 1300, 3'b010, 3'b011, 3'b001);

        // Reset mid-count on ch2; afterwards ch2 re-initialises instead of firing
        send("f_x1",    2, 61000, 3'b000, 3'b011, 3'b001);
        send("f_x2",    2, 61000, 3'b000, 3'b011, 3'b001);
        do_reset("reset_mid");
        send("g_init2", 2, 61000, 3'b000, 3'b000, 3'b000);
        send("g_2",     2, 61000, 3'b000, 3'b000, 3'b000);
        send("g_3",     2, 61000, 3'b000, 3'b000, 3'b000);
        send("g_init0", 0,  1300, 3'b000, 3'b000, 3'b000);

        // Threshold near full scale must not wrap
        send("h_init1", 1, 65500, 3'b000, 3'b000, 3'b000);
        send("h_1",     1, 65535, 3'b000, 3'b000, 3'b000);
        send("h_2",     1, 65535, 3'b000, 3'b000, 3'b000);
        send("h_3",     1, 65535, 3'b000, 3'b000, 3'b000);

        drain("final");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
